// File: rtl/instruction_writeback_pkg.sv
// instruction_writeback_pkg: shared CPSR flag positions, writeback defaults and state/mode encodings.
package instruction_writeback_pkg;
    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;
    localparam int WB_PC_INDEX = 15;
    localparam logic [31:0] WB_CPSR_RESET = 32'h000000D3;
    typedef enum logic {IDLE, WRITE_HI} wb_state_t;
    typedef enum logic [1:0] {FLAG_LOAD, FLAG_ALU, FLAG_MUL} flag_mode_t;
endpackage

// File: rtl/writeback_flag_unit.sv
// writeback_flag_unit: combinational next-CPSR from ALU/multiplier result and the current CPSR.
module writeback_flag_unit
    import instruction_writeback_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   result,
    input  logic [2*DATA_WIDTH-1:0] m_result,
    input  logic                    long_mul,
    input  flag_mode_t              mode,
    input  logic [DATA_WIDTH-1:0]   cpsr,
    output logic [DATA_WIDTH-1:0]   next_cpsr
);
    logic n, z;
    always_comb begin
        n = mode == FLAG_ALU ? result[DATA_WIDTH-1] :
            long_mul ? m_result[2*DATA_WIDTH-1] : m_result[DATA_WIDTH-1];
        z = mode == FLAG_ALU ? result == '0 :
            long_mul ? m_result == '0 : m_result[DATA_WIDTH-1:0] == '0;
        next_cpsr = cpsr;
        next_cpsr[CPSR_N] = n;
        next_cpsr[CPSR_Z] = z;
        // Compare/test ops deliver the complete new CPSR in result
        if (mode == FLAG_LOAD) next_cpsr = result;
    end
endmodule

// File: rtl/instruction_writeback.sv
// instruction_writeback: final pipeline stage driving the register write port and CPSR;
// long multiplies are split into a low write then a high write while stalling execute.
module instruction_writeback
    import instruction_writeback_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 4,
    parameter int                    PC_INDEX       = WB_PC_INDEX,
    parameter logic [DATA_WIDTH-1:0] CPSR_RESET     = WB_CPSR_RESET
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_i,
    input  logic [REG_ADDR_WIDTH-1:0] dest_hi_i,
    input  logic                      write_dest_do_i,
    input  logic                      write_dest_m_i,
    input  logic                      long_i,
    input  logic                      write_cpsr_i,
    input  logic [DATA_WIDTH-1:0]     result_i,
    input  logic [2*DATA_WIDTH-1:0]   m_result_i,
    output logic                      reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_o,
    output logic [DATA_WIDTH-1:0]     reg_data_o,
    output logic [DATA_WIDTH-1:0]     cpsr_o,
    output logic                      busy_o,
    output logic                      flush_o
);
    localparam logic [REG_ADDR_WIDTH-1:0] PC_ADDR = REG_ADDR_WIDTH'(PC_INDEX);

    wb_state_t                 state;
    flag_mode_t                flag_mode;
    logic                      wr;
    logic [REG_ADDR_WIDTH-1:0] hi_addr;
    logic [DATA_WIDTH-1:0]     hi_data, next_cpsr;

    assign wr = write_dest_do_i | write_dest_m_i;
    assign flag_mode = write_dest_do_i ? FLAG_ALU : write_dest_m_i ? FLAG_MUL : FLAG_LOAD;

    writeback_flag_unit #(.DATA_WIDTH(DATA_WIDTH)) u_flags (
        .result    (result_i),
        .m_result  (m_result_i),
        .long_mul  (long_i),
        .mode      (flag_mode),
        .cpsr      (cpsr_o),
        .next_cpsr (next_cpsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            reg_we_o   <= 1'b0;
            reg_addr_o <= '0;
            reg_data_o <= '0;
            cpsr_o     <= CPSR_RESET;
            busy_o     <= 1'b0;
            flush_o    <= 1'b0;
            hi_addr    <= '0;
            hi_data    <= '0;
        end else if (state == WRITE_HI) begin
            // Execute is holding its outputs, so inputs are ignored here
            state      <= IDLE;
            reg_we_o   <= 1'b1;
            reg_addr_o <= hi_addr;
            reg_data_o <= hi_data;
            busy_o     <= 1'b0;
            flush_o    <= hi_addr == PC_ADDR;
        end else begin
            reg_we_o <= valid_i & wr;
            flush_o  <= valid_i & wr & (dest_i == PC_ADDR);
            busy_o   <= 1'b0;
            if (valid_i && wr) begin
                reg_addr_o <= dest_i;
                reg_data_o <= write_dest_do_i ? result_i : m_result_i[DATA_WIDTH-1:0];
            end
            if (valid_i && write_cpsr_i) cpsr_o <= next_cpsr;
            if (valid_i && !write_dest_do_i && write_dest_m_i && long_i) begin
                hi_addr <= dest_hi_i;
                hi_data <= m_result_i[2*DATA_WIDTH-1:DATA_WIDTH];
                busy_o  <= 1'b1;
                state   <= WRITE_HI;
            end
        end
    end
endmodule

// File: tb/tb_instruction_writeback.sv
// tb_instruction_writeback: directed self-checking bench for instruction_writeback.
module tb_instruction_writeback;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0, write_dest_do_i = 1'b0, write_dest_m_i = 1'b0;
    logic        long_i = 1'b0, write_cpsr_i = 1'b0;
    logic [3:0]  dest_i = '0, dest_hi_i = '0;
    logic [31:0] result_i = '0;
    logic [63:0] m_result_i = '0;
    logic        reg_we_o, busy_o, flush_o;
    logic [3:0]  reg_addr_o;
    logic [31:0] reg_data_o, cpsr_o;
    int          checks = 0, errors = 0;
    wire  [38:0] obs = {reg_we_o, reg_addr_o, reg_data_o, busy_o, flush_o};

    instruction_writeback dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .dest_i(dest_i), .dest_hi_i(dest_hi_i),
        .write_dest_do_i(write_dest_do_i), .write_dest_m_i(write_dest_m_i), .long_i(long_i),
        .write_cpsr_i(write_cpsr_i), .result_i(result_i), .m_result_i(m_result_i),
        .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
        .cpsr_o(cpsr_o), .busy_o(busy_o), .flush_o(flush_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic d, input logic m, input logic l, input logic c,
                         input logic [3:0] dst, input logic [3:0] dhi,
                         input logic [31:0] r, input logic [63:0] mr);
        valid_i = v; write_dest_do_i = d; write_dest_m_i = m; long_i = l; write_cpsr_i = c;
        dest_i = dst; dest_hi_i = dhi; result_i = r; m_result_i = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 4'd0, 4'd0, 32'h0, 64'h0);
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, 1, 4'd7, 4'd0, 32'h80000000, 64'h0);
        tick();
        checks++;
        if (obs !== {1'b1, 4'd7, 32'h80000000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL pre_reset_write got %h exp %h", obs, {1'b1, 4'd7, 32'h80000000, 1'b0, 1'b0});
        end
        idle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 39'h0) begin errors++; $display("FAIL async_reset_outputs got %h exp 0", obs); end
        checks++;
        if (cpsr_o !== 32'h000000D3) begin errors++; $display("FAIL async_reset_cpsr got %h exp 000000d3", cpsr_o); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_long();
        drive(1, 0, 1, 1, 0, 4'd2, 4'd6, 32'h0, 64'h11111111_22222222);
        tick();
        idle();
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("FAIL mid_long_busy got %b exp 1", busy_o); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs !== 39'h0) begin errors++; $display("FAIL mid_long_reset got %h exp 0", obs); end
        @(posedge clk); #1 rst = 1'b0;
        tick();
        checks++;
        if (reg_we_o !== 1'b0) begin errors++; $display("FAIL abandoned_hi_write got we %b exp 0", reg_we_o); end
    endtask

    task automatic test_alu_write();
        drive(1, 1, 0, 0, 0, 4'd3, 4'd0, 32'h12345678, 64'h0);
        tick();
        idle();
        checks++;
        if (obs !== {1'b1, 4'd3, 32'h12345678, 1'b0, 1'b0}) begin
            errors++; $display("FAIL alu_write got %h exp %h", obs, {1'b1, 4'd3, 32'h12345678, 1'b0, 1'b0});
        end
        checks++;
        if (cpsr_o !== 32'h000000D3) begin errors++; $display("FAIL alu_no_cpsr got %h exp 000000d3", cpsr_o); end
        drive(1, 1, 0, 0, 0, 4'd9, 4'd0, 32'hDEADBEEF, 64'h0);
        tick();
        drive(0, 1, 0, 0, 0, 4'd9, 4'd0, 32'hCAFEF00D, 64'h0);
        tick();
        idle();
        checks++;
        if (reg_we_o !== 1'b0 || flush_o !== 1'b0) begin
            errors++; $display("FAIL invalid_ignored got we %b flush %b exp 0 0", reg_we_o, flush_o);
        end
    endtask

    task automatic test_long_mul();
        drive(1, 0, 1, 1, 0, 4'd2, 4'd5, 32'h0, 64'hAAAA0000_00005555);
        tick();
        drive(1, 1, 0, 0, 0, 4'd9, 4'd0, 32'h99999999, 64'h0);
        checks++;
        if (obs !== {1'b1, 4'd2, 32'h00005555, 1'b1, 1'b0}) begin
            errors++; $display("FAIL long_lo got %h exp %h", obs, {1'b1, 4'd2, 32'h00005555, 1'b1, 1'b0});
        end
        tick();
        idle();
        checks++;
        if (obs !== {1'b1, 4'd5, 32'hAAAA0000, 1'b0, 1'b0}) begin
            errors++; $display("FAIL long_hi got %h exp %h", obs, {1'b1, 4'd5, 32'hAAAA0000, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (reg_we_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL long_after got we %b busy %b exp 0 0", reg_we_o, busy_o);
        end
    endtask

    task automatic test_short_mul_and_priority();
        drive(1, 0, 1, 0, 0, 4'd4, 4'd8, 32'h0, 64'hFFFFFFFF_80000001);
        tick();
        drive(1, 1, 1, 1, 0, 4'd6, 4'd7, 32'h0BADF00D, 64'h12345678_9ABCDEF0);
        checks++;
        if (obs !== {1'b1, 4'd4, 32'h80000001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL short_mul got %h exp %h", obs, {1'b1, 4'd4, 32'h80000001, 1'b0, 1'b0});
        end
        tick();
        idle();
        checks++;
        if (obs !== {1'b1, 4'd6, 32'h0BADF00D, 1'b0, 1'b0}) begin
            errors++; $display("FAIL do_priority got %h exp %h", obs, {1'b1, 4'd6, 32'h0BADF00D, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (reg_we_o !== 1'b0) begin errors++; $display("FAIL priority_no_hi got we %b exp 0", reg_we_o); end
    endtask

    task automatic test_cpsr_alu();
        drive(1, 0, 0, 0, 1, 4'd0, 4'd0, 32'h600000D3, 64'h0);
        tick();
        checks++;
        if (cpsr_o !== 32'h600000D3 || reg_we_o !== 1'b0) begin
            errors++; $display("FAIL cpsr_verbatim got %h we %b exp 600000d3 0", cpsr_o, reg_we_o);
        end
        drive(1, 0, 0, 0, 1, 4'd0, 4'd0, 32'h300000D3, 64'h0);
        tick();
        drive(1, 1, 0, 0, 1, 4'd1, 4'd0, 32'h0, 64'h0);
        tick();
        checks++;
        if (obs !== {1'b1, 4'd1, 32'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL s_op_write got %h exp %h", obs, {1'b1, 4'd1, 32'h0, 1'b0, 1'b0});
        end
        checks++;
        if (cpsr_o !== 32'h700000D3) begin errors++; $display("FAIL s_op_zero got %h exp 700000d3", cpsr_o); end
        drive(1, 1, 0, 0, 1, 4'd1, 4'd0, 32'h80000000, 64'h0);
        tick();
        checks++;
        if (cpsr_o !== 32'hB00000D3) begin errors++; $display("FAIL s_op_neg got %h exp b00000d3", cpsr_o); end
        drive(0, 0, 0, 0, 1, 4'd0, 4'd0, 32'h0, 64'h0);
        tick();
        checks++;
        if (cpsr_o !== 32'hB00000D3) begin errors++; $display("FAIL cpsr_invalid_ignored got %h exp b00000d3", cpsr_o); end
        idle();
    endtask

    task automatic test_cpsr_mul();
        drive(1, 0, 1, 1, 1, 4'd2, 4'd3, 32'h0, 64'h0);
        tick();
        idle();
        checks++;
        if (cpsr_o !== 32'h700000D3) begin errors++; $display("FAIL mul_long_zero got %h exp 700000d3", cpsr_o); end
        tick();
        checks++;
        if (obs !== {1'b1, 4'd3, 32'h0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mul_long_zero_hi got %h exp %h", obs, {1'b1, 4'd3, 32'h0, 1'b0, 1'b0});
        end
        drive(1, 0, 1, 0, 1, 4'd4, 4'd0, 32'h0, 64'h00000001_80000000);
        tick();
        checks++;
        if (cpsr_o !== 32'hB00000D3) begin errors++; $display("FAIL mul_short_neg got %h exp b00000d3", cpsr_o); end
        drive(1, 0, 1, 1, 1, 4'd4, 4'd5, 32'h0, 64'h00000001_00000000);
        tick();
        idle();
        checks++;
        if (cpsr_o !== 32'h300000D3) begin errors++; $display("FAIL mul_long_nonzero got %h exp 300000d3", cpsr_o); end
        tick();
        checks++;
        if (obs !== {1'b1, 4'd5, 32'h00000001, 1'b0, 1'b0}) begin
            errors++; $display("FAIL mul_long_hi got %h exp %h", obs, {1'b1, 4'd5, 32'h00000001, 1'b0, 1'b0});
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 0, 0, 0, 4'd15, 4'd0, 32'h00008000, 64'h0);
        tick();
        idle();
        checks++;
        if (obs !== {1'b1, 4'd15, 32'h00008000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL pc_write_flush got %h exp %h", obs, {1'b1, 4'd15, 32'h00008000, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if (flush_o !== 1'b0) begin errors++; $display("FAIL flush_one_cycle got %b exp 0", flush_o); end
        drive(1, 0, 1, 1, 0, 4'd2, 4'd15, 32'h0, 64'h00004000_00000007);
        tick();
        idle();
        checks++;
        if (flush_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL long_pc_lo got flush %b busy %b exp 0 1", flush_o, busy_o);
        end
        tick();
        checks++;
        if (obs !== {1'b1, 4'd15, 32'h00004000, 1'b0, 1'b1}) begin
            errors++; $display("FAIL long_pc_hi got %h exp %h", obs, {1'b1, 4'd15, 32'h00004000, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if (flush_o !== 1'b0) begin errors++; $display("FAIL long_pc_after got %b exp 0", flush_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 4; i++) begin
            drive(1, 1, 0, 0, 0, 4'(i), 4'd0, 32'h1000 * i, 64'h0);
            tick();
            checks++;
            if (obs !== {1'b1, 4'(i), 32'h1000 * i, 1'b0, 1'b0}) begin
                errors++; $display("FAIL back_to_back_%0d got %h exp %h", i, obs, {1'b1, 4'(i), 32'h1000 * i, 1'b0, 1'b0});
            end
        end
        idle();
        tick();
        checks++;
        if (reg_we_o !== 1'b0) begin errors++; $display("FAIL back_to_back_idle got %b exp 0", reg_we_o); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_reset_mid_long();
        test_alu_write();
        test_long_mul();
        test_short_mul_and_priority();
        test_cpsr_alu();
        test_cpsr_mul();
        test_flush();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_writeback.md
Name: instruction_writeback

Overview:
Final pipeline stage; consumes the registered outputs of the execute stage (ALU result, 64-bit multiplier result, destination and write-enable strobes) and drives the register bank's single write port plus the CPSR register. Long multiplies (64-bit results) are serialised into two register writes, stalling the execute stage for one cycle. Writes to r15 raise a one-cycle pipeline flush strobe.

Parameters:
DATA_WIDTH, 32, register and ALU result width
REG_ADDR_WIDTH, 4, register index width
PC_INDEX, 15, register index treated as program counter
CPSR_RESET, 32'h000000D3, CPSR value after reset (SVC mode, IRQ/FIQ masked)

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous, active-high
valid_i  input  1  execute outputs valid this cycle
dest_i  input  4  destination register (RdLo for long multiply)
dest_hi_i  input  4  RdHi for long multiply
write_dest_do_i  input  1  write ALU result to dest_i
write_dest_m_i  input  1  write multiplier result
long_i  input  1  multiplier result is 64-bit (SMULL/SMLAL/UMULL/UMLAL)
write_cpsr_i  input  1  update CPSR
result_i  input  32  ALU result
m_result_i  input  64  multiplier result
reg_we_o  output  1  register bank write enable
reg_addr_o  output  4  register bank write index
reg_data_o  output  32  register bank write data
cpsr_o  output  32  current CPSR
busy_o  output  1  stall request to execute stage
flush_o  output  1  r15 written; flush fetch/decode

Behaviour:
- Reset (async, immediate): reg_we_o=0, reg_addr_o=0, reg_data_o=0, cpsr_o=CPSR_RESET, busy_o=0, flush_o=0, state=IDLE, hi latch cleared. Reset mid-long-multiply abandons the pending high write.
- All outputs registered; latency one clk from accepted input to reg_we_o/cpsr_o change.
- States: IDLE, WRITE_HI.
- IDLE, valid_i=0: reg_we_o=0, flush_o=0, cpsr unchanged.
- IDLE, valid_i=1, priority write_dest_do_i > write_dest_m_i:
  - do: reg_we_o=1, addr=dest_i, data=result_i.
  - m, long_i=0: addr=dest_i, data=m_result_i[31:0].
  - m, long_i=1: addr=dest_i, data=m_result_i[31:0]; latch dest_hi_i and m_result_i[63:32]; busy_o=1; go WRITE_HI.
  - neither: reg_we_o=0.
- WRITE_HI: reg_we_o=1, addr=latched RdHi, data=latched high word, busy_o=0, return IDLE. Inputs ignored in this cycle (execute stage holds while busy_o=1). RdHi==RdLo: high word is final value.
- CPSR, valid_i=1 & write_cpsr_i:
  - without write_dest_do_i (CMP/CMN/TST/TEQ): cpsr_o <= result_i verbatim.
  - with write_dest_do_i (S-suffixed data op): N=result_i[31], Z=(result_i==0), C,V and [27:0] retained.
  - with write_dest_m_i: N from bit 31 (short) or 63 (long) of m_result_i; Z from 32-/64-bit zero test; C,V retained.
- flush_o=1 for exactly the cycle any register write to PC_INDEX is issued (including the WRITE_HI cycle).
- write_cpsr_i with valid_i=0 ignored.

Decomposition:
- Shared package: CPSR bit positions (N=31, Z=30, C=29, V=28), PC_INDEX, CPSR_RESET, writeback state encoding.
- One sub-module: writeback_flag_unit (combinational next-CPSR from result, mode, current CPSR).

Test Plan:
- Reset asserted mid-cycle, no clk edge -> outputs immediately zero, cpsr_o=32'h000000D3.
- valid, do, dest=3, result=32'h12345678 -> next cycle reg_we_o=1, addr=3, data=32'h12345678, busy_o=0.
- valid, m, long, dest=2, dest_hi=5, m_result=64'hAAAA0000_00005555 -> cycle1 r2=32'h00005555, busy_o=1; cycle2 r5=32'hAAAA0000; then idle.
- valid, write_cpsr only, result=32'h600000D3 -> cpsr_o=32'h600000D3, reg_we_o=0.
- valid, do+write_cpsr, result=0, cpsr=32'h300000D3 -> reg written 0, cpsr_o=32'h700000D3 (Z set, N clear, C/V kept).
- valid, do, dest=15 -> flush_o high one cycle; long multiply with dest_hi=15 -> flush_o only in second cycle.
